// File: rtl/mode_sequencer_pkg.sv
// Shared mode encoding and helpers for the front-panel mode sequencer.
// Pure declarations: no timing, no flow control.
package mode_sequencer_pkg;

  typedef logic [1:0] mode_t;

  localparam logic [1:0] MODE_CLK12 = 2'b00;
  localparam logic [1:0] MODE_CLK24 = 2'b01;
  localparam logic [1:0] MODE_TIMER = 2'b10;
  localparam logic [1:0] MODE_STOPW = 2'b11;

  function automatic mode_t next_mode(input mode_t m);
    return mode_t'(m + 2'd1);
  endfunction

  function automatic logic [3:0] mode_onehot(input mode_t m);
    return 4'b0001 << m;
  endfunction

endpackage

// File: rtl/mode_sequencer_btn.sv
// Button conditioner: 2-flop sync, tick-based debounce, one-clk press pulse on rising level.
// Latency 2 clk + DEBOUNCE_MS ticks + 1 clk; no backpressure, a press is a single pulse.
module btn_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_khz,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_MS);

  logic [1:0]    sync_q, sync_d;
  logic          level_q, level_d;
  logic          level_prev_q, level_prev_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  always_comb begin
    sync_d       = {sync_q[0], btn_raw};
    level_d      = level_q;
    cnt_d        = cnt_q;
    cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    level_prev_d = level_q;
    press_d      = level_q & ~level_prev_q;
    // Any sample that agrees with the accepted level restarts the stability window.
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (tick_khz) begin
      if (cnt_inc == CNT_MAX) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q       <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync_q       <= sync_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      press_q      <= press_d;
      cnt_q        <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/mode_sequencer.sv
// Front-panel mode/run/clear sequencer with blinking timer alarm for the time-display mux.
// Outputs change 1 clk after a press pulse; no backpressure, presses lost to arbitration are dropped.
module mode_sequencer #(
  parameter int DEBOUNCE_MS = 20,
  parameter int ALARM_MS    = 5000,
  parameter int BLINK_MS    = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_khz,
  input  logic       btn_mode,
  input  logic       btn_run,
  input  logic       btn_clear,
  input  logic       timer_zero,
  output logic [1:0] select,
  output logic [3:0] mode_led,
  output logic       timer_run,
  output logic       sw_run,
  output logic       clear_timer,
  output logic       clear_sw,
  output logic       alarm
);
  import mode_sequencer_pkg::*;

  localparam int AW = $clog2(ALARM_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);
  localparam logic [AW-1:0] ALARM_MAX = AW'(ALARM_MS);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_MS);

  logic          p_mode, p_run, p_clear, any_press, trigger;
  mode_t         mode_q, mode_d;
  logic          timer_run_q, timer_run_d;
  logic          sw_run_q, sw_run_d;
  logic          clear_timer_q, clear_timer_d;
  logic          clear_sw_q, clear_sw_d;
  logic          alarm_q, alarm_d;
  logic          alarm_act_q, alarm_act_d;
  logic          tz_q, tz_d;
  logic [AW-1:0] alarm_cnt_q, alarm_cnt_d, alarm_inc;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d, blink_inc;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_mode (
    .clk(clk), .reset(reset), .tick_khz(tick_khz), .btn_raw(btn_mode), .press(p_mode)
  );
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_run (
    .clk(clk), .reset(reset), .tick_khz(tick_khz), .btn_raw(btn_run), .press(p_run)
  );
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_clear (
    .clk(clk), .reset(reset), .tick_khz(tick_khz), .btn_raw(btn_clear), .press(p_clear)
  );

  assign any_press = p_mode | p_run | p_clear;
  assign trigger   = timer_zero & ~tz_q & timer_run_q;
  assign alarm_inc = (alarm_cnt_q == ALARM_MAX) ? alarm_cnt_q : alarm_cnt_q + AW'(1);
  assign blink_inc = (blink_cnt_q == BLINK_MAX) ? blink_cnt_q : blink_cnt_q + BW'(1);

  always_comb begin
    mode_d        = mode_q;
    timer_run_d   = timer_run_q;
    sw_run_d      = sw_run_q;
    clear_timer_d = 1'b0;
    clear_sw_d    = 1'b0;
    alarm_d       = alarm_q;
    alarm_act_d   = alarm_act_q;
    alarm_cnt_d   = alarm_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    tz_d          = timer_zero;

    if (alarm_act_q && any_press) begin
      // Any press while the alarm sounds only silences it.
      alarm_act_d = 1'b0;
      alarm_d     = 1'b0;
      alarm_cnt_d = '0;
      blink_cnt_d = '0;
    end else begin
      if (p_clear) begin
        case (mode_q)
          MODE_TIMER: clear_timer_d = ~timer_run_q;
          MODE_STOPW: begin
            sw_run_d   = 1'b0;
            clear_sw_d = 1'b1;
          end
          default: ;
        endcase
      end else if (p_run) begin
        case (mode_q)
          MODE_TIMER: begin
            if (timer_run_q)     timer_run_d = 1'b0;
            else if (!timer_zero) timer_run_d = 1'b1;
          end
          MODE_STOPW: sw_run_d = ~sw_run_q;
          default: ;
        endcase
      end else if (p_mode) begin
        mode_d = next_mode(mode_q);
      end

      if (alarm_act_q && tick_khz) begin
        if (alarm_inc == ALARM_MAX) begin
          alarm_act_d = 1'b0;
          alarm_d     = 1'b0;
          alarm_cnt_d = '0;
          blink_cnt_d = '0;
        end else begin
          alarm_cnt_d = alarm_inc;
          if (blink_inc == BLINK_MAX) begin
            alarm_d     = ~alarm_q;
            blink_cnt_d = '0;
          end else begin
            blink_cnt_d = blink_inc;
          end
        end
      end
    end

    if (trigger) begin
      timer_run_d = 1'b0;
      alarm_act_d = 1'b1;
      alarm_d     = 1'b1;
      alarm_cnt_d = '0;
      blink_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q        <= MODE_CLK12;
      timer_run_q   <= 1'b0;
      sw_run_q      <= 1'b0;
      clear_timer_q <= 1'b0;
      clear_sw_q    <= 1'b0;
      alarm_q       <= 1'b0;
      alarm_act_q   <= 1'b0;
      alarm_cnt_q   <= '0;
      blink_cnt_q   <= '0;
      tz_q          <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      timer_run_q   <= timer_run_d;
      sw_run_q      <= sw_run_d;
      clear_timer_q <= clear_timer_d;
      clear_sw_q    <= clear_sw_d;
      alarm_q       <= alarm_d;
      alarm_act_q   <= alarm_act_d;
      alarm_cnt_q   <= alarm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      tz_q          <= tz_d;
    end
  end

  assign select      = mode_q;
  assign mode_led    = mode_onehot(mode_q);
  assign timer_run   = timer_run_q;
  assign sw_run      = sw_run_q;
  assign clear_timer = clear_timer_q;
  assign clear_sw    = clear_sw_q;
  assign alarm       = alarm_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: random press sequences against an event-level model,
// plus directed latency, bounce, alarm and reset scenarios.
module tb_mode_sequencer;

  localparam int DEB    = 2;
  localparam int ALM    = 8;
  localparam int BLK    = 2;
  localparam int TDIV   = 4;
  localparam int SETTLE = 2 + (DEB + 1) * TDIV + 4;

  logic       clk, reset, tick_khz, btn_mode, btn_run, btn_clear, timer_zero;
  logic [1:0] select;
  logic [3:0] mode_led;
  logic       timer_run, sw_run, clear_timer, clear_sw, alarm;

  int vec_cnt = 0;
  int err_cnt = 0;
  bit tick_en = 1'b1;
  int tcnt    = 0;

  int   ct_total = 0, cs_total = 0, sel_chg = 0;
  logic sw_at_clr = 1'b0;
  logic [1:0] sel_prev = 2'b00;

  int m_mode = 0;
  bit m_trun = 0, m_srun = 0, m_tz = 0;

  mode_sequencer #(.DEBOUNCE_MS(DEB), .ALARM_MS(ALM), .BLINK_MS(BLK)) dut (
    .clk(clk), .reset(reset), .tick_khz(tick_khz),
    .btn_mode(btn_mode), .btn_run(btn_run), .btn_clear(btn_clear),
    .timer_zero(timer_zero), .select(select), .mode_led(mode_led),
    .timer_run(timer_run), .sw_run(sw_run), .clear_timer(clear_timer),
    .clear_sw(clear_sw), .alarm(alarm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick_khz = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt     = (tcnt + 1) % TDIV;
      tick_khz = tick_en && (tcnt == 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (clear_timer === 1'b1) ct_total++;
      if (clear_sw === 1'b1) begin
        cs_total++;
        sw_at_clr = sw_run;
      end
      if (select !== sel_prev) sel_chg++;
      sel_prev = select;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vec_cnt);
    $fatal(1, "watchdog expired");
  end

  // Event-level reference: one accepted press, priority clear > run > mode.
  task automatic model_press(input logic [2:0] mask, output int ect, output int ecs);
    ect = 0;
    ecs = 0;
    if (mask[2]) begin
      if (m_mode == 2 && !m_trun) ect = 1;
      if (m_mode == 3) begin
        m_srun = 0;
        ecs    = 1;
      end
    end else if (mask[1]) begin
      if (m_mode == 2) begin
        if (m_trun) m_trun = 0;
        else if (!m_tz) m_trun = 1;
      end else if (m_mode == 3) begin
        m_srun = !m_srun;
      end
    end else if (mask[0]) begin
      m_mode = (m_mode + 1) % 4;
    end
  endtask

  // mask = {clear, run, mode}
  task automatic press(input logic [2:0] mask);
    @(posedge clk);
    #1;
    btn_clear = mask[2];
    btn_run   = mask[1];
    btn_mode  = mask[0];
    repeat (SETTLE + int'($urandom_range(0, 3))) @(posedge clk);
    #1;
    btn_clear = 1'b0;
    btn_run   = 1'b0;
    btn_mode  = 1'b0;
    repeat (SETTLE + int'($urandom_range(0, 3))) @(posedge clk);
    #1;
  endtask

  task automatic press_model(input logic [2:0] mask);
    int a, b;
    press(mask);
    model_press(mask, a, b);
  endtask

  task automatic goto_mode(input int target);
    for (int i = 0; i < 4 && m_mode != target; i++) press_model(3'b001);
  endtask

  task automatic set_tz(input bit v);
    timer_zero = v;
    m_tz       = v;
  endtask

  task automatic test_reset;
    reset = 1'b0; btn_mode = 0; btn_run = 0; btn_clear = 0; timer_zero = 0;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if ({select, mode_led, timer_run, sw_run, clear_timer, clear_sw, alarm} !== 11'b00_0001_00000) begin
      err_cnt++;
      $display("FAIL reset_state: got %b want %b",
               {select, mode_led, timer_run, sw_run, clear_timer, clear_sw, alarm}, 11'b00_0001_00000);
    end
    reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    vec_cnt++;
    if ({select, mode_led, timer_run, sw_run, alarm, sel_chg, ct_total, cs_total} !==
        {2'b00, 4'b0001, 3'b000, 32'd0, 32'd0, 32'd0}) begin
      err_cnt++;
      $display("FAIL reset_release: sel %b led %b tr %b sw %b al %b chg %0d ct %0d cs %0d want idle",
               select, mode_led, timer_run, sw_run, alarm, sel_chg, ct_total, cs_total);
    end
  endtask

  task automatic test_mode_latency;
    int n, ticks, ek, bad, old_m, new_m;
    logic t;
    for (int i = 0; i < 4; i++) begin
      old_m = m_mode;
      new_m = (m_mode + 1) % 4;
      @(posedge clk);
      #1;
      btn_mode = 1'b1;
      n = 0; ticks = 0; ek = 0; bad = 0;
      while (n < 200 && (ek == 0 || n < ek + 4)) begin
        @(negedge clk);
        if (select !== 2'((ek != 0 && n >= ek + 2) ? new_m : old_m)) bad++;
        t = tick_khz;
        @(posedge clk);
        n++;
        if (n >= 3 && t) begin
          ticks++;
          if (ticks == DEB) ek = n;
        end
      end
      vec_cnt++;
      if (bad != 0 || ek == 0) begin
        err_cnt++;
        $display("FAIL mode_latency[%0d]: %0d cycles off expected select timeline (2 clk + %0d ticks + 2 clk), want 0",
                 i, bad, DEB);
      end
      #1;
      btn_mode = 1'b0;
      repeat (SETTLE) @(posedge clk);
      #1;
      m_mode = new_m;
      vec_cnt++;
      if ({select, mode_led} !== {2'(m_mode), 4'(1 << m_mode)}) begin
        err_cnt++;
        $display("FAIL mode_step[%0d]: got sel %b led %b want sel %0d led %b",
                 i, select, mode_led, m_mode, 4'(1 << m_mode));
      end
    end
  endtask

  task automatic test_bounce;
    int chg0;
    chg0 = sel_chg;
    @(posedge clk);
    #1;
    for (int j = 0; j < 10; j++) begin
      btn_mode = (j % 2 == 0);
      repeat (TDIV / 2) @(posedge clk);
      #1;
    end
    btn_mode = 1'b1;
    repeat (SETTLE) @(posedge clk);
    #1;
    btn_mode = 1'b0;
    repeat (SETTLE) @(posedge clk);
    #1;
    m_mode = (m_mode + 1) % 4;
    vec_cnt++;
    if (select !== 2'(m_mode) || sel_chg - chg0 != 1) begin
      err_cnt++;
      $display("FAIL bounce: sel %0d after %0d changes, want sel %0d after 1 change",
               select, sel_chg - chg0, m_mode);
    end
  endtask

  task automatic test_stuck_tick;
    int chg0;
    chg0    = sel_chg;
    tick_en = 1'b0;
    press(3'b001);
    repeat (10) @(posedge clk);
    tick_en = 1'b1;
    repeat (SETTLE) @(posedge clk);
    #1;
    vec_cnt++;
    if (select !== 2'(m_mode) || sel_chg != chg0) begin
      err_cnt++;
      $display("FAIL stuck_tick: sel %0d changes %0d, want sel %0d changes 0", select, sel_chg - chg0, m_mode);
    end
  endtask

  task automatic test_timer_ctrl;
    int ct0;
    goto_mode(2);
    set_tz(1'b0);
    press_model(3'b010);
    vec_cnt++;
    if (timer_run !== 1'b1) begin
      err_cnt++; $display("FAIL timer_start: timer_run %b want 1", timer_run);
    end
    ct0 = ct_total;
    press_model(3'b100);
    vec_cnt++;
    if (timer_run !== 1'b1 || ct_total != ct0) begin
      err_cnt++; $display("FAIL timer_clear_running: timer_run %b pulses %0d, want 1 and 0", timer_run, ct_total - ct0);
    end
    press_model(3'b010);
    ct0 = ct_total;
    press_model(3'b100);
    vec_cnt++;
    if (timer_run !== 1'b0 || ct_total - ct0 != 1) begin
      err_cnt++; $display("FAIL timer_clear_stopped: timer_run %b pulses %0d, want 0 and 1", timer_run, ct_total - ct0);
    end
    set_tz(1'b1);
    press_model(3'b010);
    vec_cnt++;
    if (timer_run !== 1'b0) begin
      err_cnt++; $display("FAIL timer_start_at_zero: timer_run %b want 0", timer_run);
    end
    set_tz(1'b0);
  endtask

  task automatic test_stopwatch;
    int cs0;
    goto_mode(3);
    press_model(3'b010);
    vec_cnt++;
    if (sw_run !== 1'b1) begin
      err_cnt++; $display("FAIL sw_start: sw_run %b want 1", sw_run);
    end
    cs0 = cs_total;
    press_model(3'b100);
    vec_cnt++;
    if (sw_run !== 1'b0 || cs_total - cs0 != 1 || sw_at_clr !== 1'b0) begin
      err_cnt++;
      $display("FAIL sw_clear: sw_run %b pulse cycles %0d sw_run_at_pulse %b, want 0, 1, 0",
               sw_run, cs_total - cs0, sw_at_clr);
    end
    press_model(3'b010);
    press_model(3'b001);
    vec_cnt++;
    if (select !== 2'b00 || sw_run !== 1'b1) begin
      err_cnt++; $display("FAIL sw_persist: sel %0d sw_run %b, want 0 and 1", select, sw_run);
    end
  endtask

  task automatic test_same_clk;
    goto_mode(3);
    press_model(3'b011);
    vec_cnt++;
    if (select !== 2'b11 || sw_run !== 1'(m_srun) || m_srun != 0) begin
      err_cnt++; $display("FAIL same_clk_run_mode: sel %0d sw_run %b, want 3 and 0", select, sw_run);
    end
  endtask

  task automatic test_alarm_blink;
    int n, k, bad;
    logic t, expa;
    goto_mode(2);
    set_tz(1'b0);
    press_model(3'b010);
    vec_cnt++;
    if (timer_run !== 1'b1) begin
      err_cnt++; $display("FAIL alarm_arm: timer_run %b want 1", timer_run);
    end
    @(posedge clk);
    #1;
    timer_zero = 1'b1;
    @(posedge clk);
    n = 1; k = 0; bad = 0;
    while (n < 400 && k < ALM + 2) begin
      @(negedge clk);
      if (n == 12) tick_en = 1'b0;
      if (n == 40) tick_en = 1'b1;
      expa = (k < ALM) && ((k / BLK) % 2 == 0);
      if (alarm !== expa || timer_run !== 1'b0) bad++;
      t = tick_khz;
      @(posedge clk);
      n++;
      if (t) k++;
    end
    m_trun = 0;
    vec_cnt++;
    if (bad != 0 || k < ALM + 2) begin
      err_cnt++; $display("FAIL alarm_blink: %0d cycles off blink pattern, %0d ticks seen, want 0 and %0d", bad, k, ALM + 2);
    end
    #1;
    set_tz(1'b0);
  endtask

  task automatic test_alarm_ack;
    int n, k, pn, pk, ek, bad;
    bit pressed;
    logic t, expa;
    press_model(3'b010);
    @(posedge clk);
    #1;
    timer_zero = 1'b1;
    @(posedge clk);
    n = 1; k = 0; pn = 0; pk = 0; ek = 0; bad = 0; pressed = 0;
    while (n < 400 && (ek == 0 || n < ek + 6)) begin
      @(negedge clk);
      if (n == 3) timer_zero = 1'b0;
      expa = (ek != 0 && n >= ek + 2) ? 1'b0 : ((k < ALM) && ((k / BLK) % 2 == 0));
      if (alarm !== expa || timer_run !== 1'b0) bad++;
      t = tick_khz;
      @(posedge clk);
      n++;
      if (t) k++;
      if (pressed) begin
        pn++;
        if (pn >= 3 && t) begin
          pk++;
          if (pk == DEB) ek = n;
        end
      end
      if (!pressed && k == 3) begin
        #1;
        btn_run = 1'b1;
        pressed = 1;
      end
    end
    #1;
    btn_run = 1'b0;
    m_trun  = 0;
    m_tz    = 0;
    vec_cnt++;
    if (bad != 0 || ek == 0) begin
      err_cnt++; $display("FAIL alarm_ack: %0d cycles off expected alarm/ack timeline, want 0", bad);
    end
    repeat (SETTLE) @(posedge clk);
    #1;
    vec_cnt++;
    if ({select, timer_run, alarm} !== 4'b1000) begin
      err_cnt++; $display("FAIL alarm_ack_consumed: sel %0d timer_run %b alarm %b, want 2 0 0", select, timer_run, alarm);
    end
  endtask

  task automatic test_reset_mid_alarm;
    press_model(3'b010);
    @(posedge clk);
    #1;
    timer_zero = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++;
    if (alarm !== 1'b1 || select !== 2'b10) begin
      err_cnt++; $display("FAIL alarm_before_reset: alarm %b sel %0d, want 1 and 2", alarm, select);
    end
    #3;
    reset = 1'b0;
    #1;
    vec_cnt++;
    if ({select, mode_led, timer_run, sw_run, clear_timer, clear_sw, alarm} !== 11'b00_0001_00000) begin
      err_cnt++;
      $display("FAIL reset_async: got %b want %b",
               {select, mode_led, timer_run, sw_run, clear_timer, clear_sw, alarm}, 11'b00_0001_00000);
    end
    repeat (3) @(posedge clk);
    #1;
    set_tz(1'b0);
    reset  = 1'b1;
    m_mode = 0; m_trun = 0; m_srun = 0;
    repeat (SETTLE) @(posedge clk);
    #1;
    vec_cnt++;
    if ({select, timer_run, sw_run, alarm} !== 5'b00000) begin
      err_cnt++; $display("FAIL reset_no_press: sel %0d tr %b sw %b al %b, want all 0", select, timer_run, sw_run, alarm);
    end
  endtask

  task automatic test_random;
    int ct0, cs0, ect, ecs;
    logic [2:0] mask;
    for (int i = 0; i < 40; i++) begin
      if (!m_trun && $urandom_range(0, 3) == 0) set_tz(1'($urandom_range(0, 1)));
      mask = 3'($urandom_range(1, 7));
      ct0  = ct_total;
      cs0  = cs_total;
      press(mask);
      model_press(mask, ect, ecs);
      vec_cnt++;
      if ({select, mode_led, timer_run, sw_run, alarm} !== {2'(m_mode), 4'(1 << m_mode), 1'(m_trun), 1'(m_srun), 1'b0}) begin
        err_cnt++;
        $display("FAIL rand_state[%0d] mask %b: sel %0d led %b tr %b sw %b al %b, want sel %0d tr %0d sw %0d al 0",
                 i, mask, select, mode_led, timer_run, sw_run, alarm, m_mode, m_trun, m_srun);
      end
      vec_cnt++;
      if (ct_total - ct0 != ect || cs_total - cs0 != ecs) begin
        err_cnt++;
        $display("FAIL rand_pulses[%0d] mask %b: clear_timer %0d clear_sw %0d, want %0d %0d",
                 i, mask, ct_total - ct0, cs_total - cs0, ect, ecs);
      end
    end
    set_tz(1'b0);
  endtask

  initial begin
    test_reset();
    test_mode_latency();
    test_bounce();
    test_stuck_tick();
    test_timer_ctrl();
    test_stopwatch();
    test_same_clk();
    test_alarm_blink();
    test_alarm_ack();
    test_reset_mid_alarm();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
